// File: rtl/fp_add_result_buffer_if.sv
// Handshake bundle between the FP adder, the result buffer and its consumer.
// Ports: in_* (adder -> buffer, valid/ready), out_* (buffer -> consumer, valid/ready).
interface fp_add_result_buffer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_overflow;
    logic        in_underflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_nan;

    modport master (
        output in_valid, in_result, in_overflow, in_underflow, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_underflow,
        input  out_nan
    );

    modport slave (
        input  in_valid, in_result, in_overflow, in_underflow, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_underflow,
        output out_nan
    );
endinterface

// File: rtl/fp_add_result_buffer.sv
// Result FIFO behind the FP adder with sticky overflow/underflow/NaN status.
// Ports: clk, rst_n (async low), bus (slave), count, flag_clr, sticky_*.
module fp_add_result_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fp_add_result_buffer_if.slave      bus,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       flag_clr,
    output logic                       sticky_overflow,
    output logic                       sticky_underflow,
    output logic                       sticky_nan
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef struct packed {
        logic [31:0] result;
        logic        ovf;
        logic        udf;
        logic        nan;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             in_nan;

    assign bus.in_ready  = (count < CNT_FULL);
    assign bus.out_valid = (count != '0);

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    assign in_nan = (bus.in_result[30:23] == 8'hFF) &&
                    (bus.in_result[22:0] != 23'd0);

    // Storage is not reset, so the head is masked until an entry exists.
    assign head = mem[rd_ptr];

    assign bus.out_result    = bus.out_valid ? head.result : 32'd0;
    assign bus.out_overflow  = bus.out_valid && head.ovf;
    assign bus.out_underflow = bus.out_valid && head.udf;
    assign bus.out_nan       = bus.out_valid && head.nan;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{
                result: bus.in_result,
                ovf:    bus.in_overflow,
                udf:    bus.in_underflow,
                nan:    in_nan
            };
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            unique case (1'b1)
                push && !pop: count <= count + CNT_ONE;
                pop && !push: count <= count - CNT_ONE;
                default:      count <= count;
            endcase
        end
    end

    // A flag raised by a push in the clearing cycle survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_overflow  <= 1'b0;
            sticky_underflow <= 1'b0;
            sticky_nan       <= 1'b0;
        end else if (flag_clr) begin
            sticky_overflow  <= push && bus.in_overflow;
            sticky_underflow <= push && bus.in_underflow;
            sticky_nan       <= push && in_nan;
        end else begin
            sticky_overflow  <= sticky_overflow  | (push && bus.in_overflow);
            sticky_underflow <= sticky_underflow | (push && bus.in_underflow);
            sticky_nan       <= sticky_nan       | (push && in_nan);
        end
    end
endmodule

// File: tb/tb_fp_add_result_buffer.sv
// Directed bench for fp_add_result_buffer (DEPTH=4).
// Drives the bus master side and checks every scenario inline.
module tb_fp_add_result_buffer;
    logic       clk;
    logic       rst_n;
    logic       flag_clr;
    logic [2:0] count;
    logic       sticky_overflow;
    logic       sticky_underflow;
    logic       sticky_nan;
    int         tests;
    int         fails;

    fp_add_result_buffer_if bus ();

    fp_add_result_buffer #(.DEPTH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .count            (count),
        .flag_clr         (flag_clr),
        .sticky_overflow  (sticky_overflow),
        .sticky_underflow (sticky_underflow),
        .sticky_nan       (sticky_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid     = 1'b0;
        bus.in_result    = 32'd0;
        bus.in_overflow  = 1'b0;
        bus.in_underflow = 1'b0;
        bus.out_ready    = 1'b0;
        flag_clr         = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        tests++;
        if (count !== 3'd0) begin
            fails++;
            $display("FAIL reset_count got %0d want 0", count);
        end
        tests++;
        if ({bus.out_result, bus.out_overflow, bus.out_underflow, bus.out_nan}
            !== 35'd0) begin
            fails++;
            $display("FAIL reset_out got %h want 0", bus.out_result);
        end
        tests++;
        if ({sticky_overflow, sticky_underflow, sticky_nan} !== 3'b000) begin
            fails++;
            $display("FAIL reset_sticky got %b%b%b want 000",
                     sticky_overflow, sticky_underflow, sticky_nan);
        end
        rst_n = 1'b1;
        tick();
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_pass_through();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_result = 32'h3F80_0000;
        tick();
        bus.in_valid = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h3F80_0000) begin
            fails++;
            $display("FAIL pass_head got v=%b %h want v=1 3f800000",
                     bus.out_valid, bus.out_result);
        end
        tests++;
        if (count !== 3'd1) begin
            fails++;
            $display("FAIL pass_count1 got %0d want 1", count);
        end
        tick();
        tests++;
        if (count !== 3'd0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL pass_drain got cnt=%0d v=%b want 0 0",
                     count, bus.out_valid);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_fill();
        logic [31:0] vals [4];
        vals = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_result = vals[i];
            tick();
        end
        tests++;
        if (count !== 3'd4 || bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL fill_full got cnt=%0d rdy=%b want 4 0",
                     count, bus.in_ready);
        end
        bus.in_result = 32'h40C0_0000;
        tick();
        tests++;
        if (count !== 3'd4 || bus.out_result !== 32'h4000_0000) begin
            fails++;
            $display("FAIL fill_reject got cnt=%0d head=%h want 4 40000000",
                     count, bus.out_result);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== vals[i]) begin
                fails++;
                $display("FAIL fill_drain%0d got v=%b %h want v=1 %h",
                         i, bus.out_valid, bus.out_result, vals[i]);
            end
            tick();
        end
        tests++;
        if (count !== 3'd0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL fill_empty got cnt=%0d rdy=%b want 0 1",
                     count, bus.in_ready);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_result = 32'h3F80_0000 + i;
            tick();
        end
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            bus.in_result = 32'h3F80_0000 + i + 2;
            tests++;
            if (bus.out_result !== 32'h3F80_0000 + i) begin
                fails++;
                $display("FAIL b2b_head%0d got %h want %h",
                         i, bus.out_result, 32'h3F80_0000 + i);
            end
            tick();
            tests++;
            if (count !== 3'd2) begin
                fails++;
                $display("FAIL b2b_count%0d got %0d want 2", i, count);
            end
        end
        bus.in_valid = 1'b0;
        for (int i = 7; i <= 8; i++) begin
            tests++;
            if (bus.out_result !== 32'h3F80_0000 + i) begin
                fails++;
                $display("FAIL b2b_tail%0d got %h want %h",
                         i, bus.out_result, 32'h3F80_0000 + i);
            end
            tick();
        end
        tests++;
        if (count !== 3'd0) begin
            fails++;
            $display("FAIL b2b_empty got %0d want 0", count);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_sticky();
        bus.out_ready    = 1'b0;
        bus.in_valid     = 1'b1;
        bus.in_result    = 32'h7F80_0000;
        bus.in_overflow  = 1'b1;
        tick();
        tests++;
        if ({sticky_overflow, sticky_underflow, sticky_nan} !== 3'b100) begin
            fails++;
            $display("FAIL sticky_ovf got %b%b%b want 100",
                     sticky_overflow, sticky_underflow, sticky_nan);
        end
        bus.in_result   = 32'h7FC0_0000;
        bus.in_overflow = 1'b0;
        tick();
        tests++;
        if ({sticky_overflow, sticky_underflow, sticky_nan} !== 3'b101) begin
            fails++;
            $display("FAIL sticky_nan got %b%b%b want 101",
                     sticky_overflow, sticky_underflow, sticky_nan);
        end
        bus.in_result    = 32'h0000_0001;
        bus.in_underflow = 1'b1;
        tick();
        tests++;
        if ({sticky_overflow, sticky_underflow, sticky_nan} !== 3'b111) begin
            fails++;
            $display("FAIL sticky_udf got %b%b%b want 111",
                     sticky_overflow, sticky_underflow, sticky_nan);
        end
        idle_inputs();
        bus.out_ready = 1'b1;
        tests++;
        if ({bus.out_nan, bus.out_overflow, bus.out_underflow} !== 3'b010) begin
            fails++;
            $display("FAIL head_inf got nan/ov/ud=%b%b%b want 010",
                     bus.out_nan, bus.out_overflow, bus.out_underflow);
        end
        tick();
        tests++;
        if (bus.out_nan !== 1'b1 || bus.out_result !== 32'h7FC0_0000) begin
            fails++;
            $display("FAIL head_nan got nan=%b %h want 1 7fc00000",
                     bus.out_nan, bus.out_result);
        end
        tick();
        tests++;
        if ({bus.out_nan, bus.out_overflow, bus.out_underflow} !== 3'b001) begin
            fails++;
            $display("FAIL head_denorm got nan/ov/ud=%b%b%b want 001",
                     bus.out_nan, bus.out_overflow, bus.out_underflow);
        end
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_clear_collision();
        bus.in_valid    = 1'b1;
        bus.in_result   = 32'h3F80_0000;
        bus.in_overflow = 1'b1;
        flag_clr        = 1'b1;
        tick();
        tests++;
        if ({sticky_overflow, sticky_underflow, sticky_nan} !== 3'b100) begin
            fails++;
            $display("FAIL clr_collide got %b%b%b want 100",
                     sticky_overflow, sticky_underflow, sticky_nan);
        end
        idle_inputs();
        flag_clr = 1'b1;
        tick();
        tests++;
        if ({sticky_overflow, sticky_underflow, sticky_nan} !== 3'b000) begin
            fails++;
            $display("FAIL clr_plain got %b%b%b want 000",
                     sticky_overflow, sticky_underflow, sticky_nan);
        end
        flag_clr      = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.out_ready   = 1'b0;
        bus.in_valid    = 1'b1;
        bus.in_overflow = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_result = 32'h4100_0000 + i;
            tick();
        end
        idle_inputs();
        tests++;
        if (count !== 3'd3 || sticky_overflow !== 1'b1) begin
            fails++;
            $display("FAIL mid_pre got cnt=%0d sov=%b want 3 1",
                     count, sticky_overflow);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || count !== 3'd0 ||
            bus.out_result !== 32'd0) begin
            fails++;
            $display("FAIL mid_reset got v=%b cnt=%0d %h want 0 0 0",
                     bus.out_valid, count, bus.out_result);
        end
        tests++;
        if ({sticky_overflow, sticky_underflow, sticky_nan} !== 3'b000) begin
            fails++;
            $display("FAIL mid_sticky got %b%b%b want 000",
                     sticky_overflow, sticky_underflow, sticky_nan);
        end
        #1;
        rst_n = 1'b1;
        tick();
        bus.in_valid  = 1'b1;
        bus.in_result = 32'h1234_5678;
        tick();
        bus.in_valid = 1'b0;
        tests++;
        if (bus.out_result !== 32'h1234_5678 || count !== 3'd1) begin
            fails++;
            $display("FAIL mid_after got %h cnt=%0d want 12345678 1",
                     bus.out_result, count);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_pass_through();
        test_fill();
        test_back_to_back();
        test_sticky();
        test_clear_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fp_add_result_buffer.md
Name: fp_add_result_buffer

Overview:
Downstream stage of the combinational single-precision FP adder. It captures each adder result together with its overflow/underflow flags into a small valid/ready FIFO. It also maintains sticky exception status (overflow, underflow, NaN-result) for the FPU status register. It decouples the adder from a stalling consumer such as writeback or the register file.

Parameters:
DEPTH, 4, number of result entries; power of two, at least 2
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  adder result present on in_* this cycle
in_ready  output  1  buffer can accept an entry this cycle
in_result  input  32  IEEE-754 single result (adder fp_result)
in_overflow  input  1  adder overflow flag for in_result
in_underflow  input  1  adder underflow flag for in_result
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head entry
out_result  output  32  head entry result
out_overflow  output  1  head entry overflow flag
out_underflow  output  1  head entry underflow flag
out_nan  output  1  head entry is NaN (exp==8'hFF, mantissa!=0)
count  output  PTR_W+1  number of occupied entries, 0..DEPTH
flag_clr  input  1  clear all sticky flags
sticky_overflow  output  1  sticky OR of accepted overflow flags
sticky_underflow  output  1  sticky OR of accepted underflow flags
sticky_nan  output  1  sticky OR of accepted NaN results

Behaviour:
- Reset (rst_n=0, asynchronous): read pointer, write pointer and count go to 0. out_valid=0, out_result=0, out_overflow=0, out_underflow=0, out_nan=0. All sticky flags = 0. in_ready=1 once rst_n deasserts. Entry storage need not be reset.
- Push: in_valid && in_ready at a rising edge. Stores {in_result, in_overflow, in_underflow, nan}, where nan is computed from in_result at push time. Write pointer increments modulo DEPTH.
- Pop: out_valid && out_ready at a rising edge. Read pointer increments modulo DEPTH.
- in_ready = (count < DEPTH). It is a function of registered state only, with no combinational path from out_ready.
- out_valid = (count != 0). out_* present the head entry (first-word fall-through from storage) and are stable while out_valid && !out_ready.
- Latency: an entry pushed at edge N is visible on out_* with out_valid=1 after edge N when the buffer was empty. Throughput is 1 entry/cycle.
- Push and pop in the same cycle: both occur and count is unchanged. When empty, no pop can occur, so count goes 0->1. When full, no push can occur, so count goes DEPTH->DEPTH-1.
- count: +1 on push only, -1 on pop only, unchanged otherwise. Never exceeds DEPTH and never underflows.
- Pointer wrap: pointers use PTR_W bits and wrap from DEPTH-1 to 0 with no gap. Full and empty are distinguished by count, not by pointers.
- Sticky flags: on each push, sticky_x <= sticky_x | entry_x. Updates are visible the cycle after the push edge.
- flag_clr at an edge clears all three flags. If a push with a flag set occurs at the same edge, that flag ends at 1 (the set wins, so no event is lost). Other flags clear.
- in_valid && !in_ready: nothing is stored and sticky flags are unaffected. The upstream holds in_* stable until accepted.
- Reset asserted mid-operation: all entries are discarded immediately, sticky flags clear, and outputs take their reset values asynchronously.
- No X propagation: out_* are 0 until the first push after reset.

Test Plan:
- Single pass-through: push 32'h3F800000 (ov=0, ud=0) into empty buffer with out_ready=1. Required: out_valid=1 one cycle later, out_result=32'h3F800000, count 0->1->0.
- Fill and backpressure (DEPTH=4): out_ready=0, push 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000. Required: in_ready=0 and count=4. A fifth in_valid with 32'h40C00000 is not accepted. Draining returns the four values in order, then in_ready=1.
- Simultaneous push/pop at count=2 for 6 cycles with incrementing results. Required: count stays 2, order is preserved, and pointers wrap past index 3 without loss.
- Sticky flags: push 32'h7F800000 with ov=1, then 32'h7FC00000 (NaN), then 32'h00000001 with ud=1. Required: sticky_overflow, sticky_nan and sticky_underflow set on successive cycles. out_nan=1 only when the 7FC00000 entry is the head.
- Clear collision: flag_clr=1 in the same cycle as a push with ov=1, ud=0, while all sticky flags are 1. Required next cycle: sticky_overflow=1, sticky_underflow=0, sticky_nan=0.
- Reset mid-stream: with count=3, drop rst_n asynchronously (between edges). Required: out_valid=0, count=0, all sticky flags=0 immediately. After release, the first push yields that value at the head.
